// File: rtl/ppu_line_doubler_if.sv
// Pixel-side bus of the PPU line doubler: PPU write port, VGA read request and
// the scan-converted output. dbg_state mirrors the controller state for checkers.
interface ppu_line_doubler_if #(
  parameter int PIX_W = 6
);
  logic             ppu_pix_valid;
  logic [7:0]       ppu_x;
  logic [8:0]       ppu_y;
  logic [PIX_W-1:0] ppu_pix;
  logic             vga_pix_en;
  logic [9:0]       draw_x;
  logic [9:0]       draw_y;
  logic [PIX_W-1:0] pix_out;
  logic             pix_active;
  logic             underrun;
  logic [7:0]       underrun_cnt;
  logic [1:0]       dbg_state;

  // Strobe semantics, no back-pressure: ppu_pix_valid and vga_pix_en are each
  // valid for exactly one cycle per pixel and are always accepted.
  modport master (
    output ppu_pix_valid, ppu_x, ppu_y, ppu_pix, vga_pix_en, draw_x, draw_y,
    input  pix_out, pix_active, underrun, underrun_cnt, dbg_state
  );

  modport slave (
    input  ppu_pix_valid, ppu_x, ppu_y, ppu_pix, vga_pix_en, draw_x, draw_y,
    output pix_out, pix_active, underrun, underrun_cnt, dbg_state
  );
endinterface

// File: rtl/ppu_line_doubler.sv
// Ping-pong line buffer that replays each 256-pixel PPU line twice, each pixel
// twice, as a 512x480 window in 640x480 VGA timing, with stale-line detection.
module ppu_line_doubler #(
  parameter int LINE_W = 256,
  parameter int LINES = 240,
  parameter int H_OFFSET = 64,
  parameter int PIX_W = 6,
  parameter logic [PIX_W-1:0] BACKDROP = PIX_W'('h0F)
) (
  input  logic              Clk,
  input  logic              reset_rtl_0,
  ppu_line_doubler_if.slave bus
);

  localparam logic [9:0] WIN_X0    = 10'(H_OFFSET);
  localparam logic [9:0] WIN_X1    = 10'(H_OFFSET + 2 * LINE_W);
  localparam logic [9:0] WIN_ROWS  = 10'(2 * LINES);
  localparam logic [8:0] NUM_LINES = 9'(LINES);
  localparam logic [7:0] LAST_X    = 8'(LINE_W - 1);

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    FILL       = 2'd1,
    RUN        = 2'd2
  } state_t;

  logic [PIX_W-1:0] mem [2*LINE_W];

  state_t           state_q, state_d;
  logic [1:0]       bank_valid_q, bank_valid_d;
  logic [1:0][8:0]  line_tag_q, line_tag_d;
  logic             line_ok_q, line_ok_d;
  logic             underrun_q, underrun_d;
  logic [7:0]       underrun_cnt_q, underrun_cnt_d;
  logic             s1_vld_q, s1_vld_d;
  logic             s1_win_q, s1_win_d;
  logic             s1_stale_q, s1_stale_d;
  logic             s1_run_q, s1_run_d;
  logic [8:0]       s1_addr_q, s1_addr_d;
  logic [PIX_W-1:0] pix_out_q, pix_out_d;
  logic             pix_active_q, pix_active_d;

  logic             wr_en;
  logic             in_win;
  logic [7:0]       src_x;
  logic [8:0]       src_y;
  logic             rd_bank;
  logic             row_start;
  logic             line_chk;
  logic             line_ok_now;
  logic [PIX_W-1:0] rd_data;

  assign wr_en     = bus.ppu_pix_valid && (bus.ppu_y < NUM_LINES);
  assign in_win    = (bus.draw_x >= WIN_X0) && (bus.draw_x < WIN_X1) && (bus.draw_y < WIN_ROWS);
  assign src_x     = 8'((bus.draw_x - WIN_X0) >> 1);
  assign src_y     = bus.draw_y[9:1];
  assign rd_bank   = src_y[0];
  assign row_start = bus.vga_pix_en && (bus.draw_x == WIN_X0) &&
                     (bus.draw_y < WIN_ROWS) && (state_q == RUN);
  assign line_chk  = bank_valid_q[rd_bank] && (line_tag_q[rd_bank] == src_y);
  // The first window pixel of a row already uses the freshly evaluated verdict.
  assign line_ok_now = row_start ? line_chk : line_ok_q;

  // Registered address feeds the array; the output register captures the value
  // before any write on the same edge, so collisions return the old pixel.
  assign rd_data = mem[s1_addr_q];

  always_ff @(posedge Clk) begin
    if (wr_en) begin
      mem[{bus.ppu_y[0], bus.ppu_x}] <= bus.ppu_pix;
    end
  end

  always_comb begin
    state_d        = state_q;
    bank_valid_d   = bank_valid_q;
    line_tag_d     = line_tag_q;
    line_ok_d      = line_ok_now;
    underrun_d     = underrun_q;
    underrun_cnt_d = underrun_cnt_q;
    s1_vld_d       = bus.vga_pix_en;
    s1_win_d       = in_win;
    s1_stale_d     = !line_ok_now;
    s1_run_d       = (state_q == RUN);
    s1_addr_d      = {rd_bank, src_x};
    pix_out_d      = pix_out_q;
    pix_active_d   = pix_active_q;

    if (wr_en) begin
      if (bus.ppu_x == 8'd0) begin
        bank_valid_d[bus.ppu_y[0]] = 1'b0;
      end
      if (bus.ppu_x == LAST_X) begin
        bank_valid_d[bus.ppu_y[0]] = 1'b1;
        line_tag_d[bus.ppu_y[0]]   = bus.ppu_y;
      end
    end

    case (state_q)
      WAIT_FRAME: if (bus.ppu_pix_valid && bus.ppu_x == 8'd0 && bus.ppu_y == 9'd0) state_d = FILL;
      FILL:       if (wr_en && bus.ppu_x == LAST_X && bus.ppu_y == 9'd0) state_d = RUN;
      RUN:        state_d = RUN;
      default:    state_d = WAIT_FRAME;
    endcase

    // Only the first replay of a source line counts, so each stale line counts once.
    if (row_start && !line_chk && !bus.draw_y[0]) begin
      underrun_d = 1'b1;
      if (underrun_cnt_q != 8'hFF) begin
        underrun_cnt_d = underrun_cnt_q + 8'd1;
      end
    end

    if (s1_vld_q) begin
      pix_out_d    = '0;
      pix_active_d = 1'b0;
      if (s1_run_q && s1_win_q) begin
        pix_active_d = 1'b1;
        pix_out_d    = s1_stale_q ? BACKDROP : rd_data;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (reset_rtl_0) begin
      state_q        <= WAIT_FRAME;
      bank_valid_q   <= 2'b00;
      line_tag_q     <= '0;
      line_ok_q      <= 1'b0;
      underrun_q     <= 1'b0;
      underrun_cnt_q <= 8'd0;
      s1_vld_q       <= 1'b0;
      s1_win_q       <= 1'b0;
      s1_stale_q     <= 1'b0;
      s1_run_q       <= 1'b0;
      s1_addr_q      <= 9'd0;
      pix_out_q      <= '0;
      pix_active_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      bank_valid_q   <= bank_valid_d;
      line_tag_q     <= line_tag_d;
      line_ok_q      <= line_ok_d;
      underrun_q     <= underrun_d;
      underrun_cnt_q <= underrun_cnt_d;
      s1_vld_q       <= s1_vld_d;
      s1_win_q       <= s1_win_d;
      s1_stale_q     <= s1_stale_d;
      s1_run_q       <= s1_run_d;
      s1_addr_q      <= s1_addr_d;
      pix_out_q      <= pix_out_d;
      pix_active_q   <= pix_active_d;
    end
  end

  assign bus.pix_out      = pix_out_q;
  assign bus.pix_active   = pix_active_q;
  assign bus.underrun     = underrun_q;
  assign bus.underrun_cnt = underrun_cnt_q;
  assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_ppu_line_doubler.sv
// Directed bench for ppu_line_doubler: a frame-level model predicts every output
// cycle, and hand-computed probes pin the model at key pixels and counters.
module tb_ppu_line_doubler;
  localparam int PIX_W = 6;
  localparam int ST_WAIT = 0;
  localparam int ST_FILL = 1;
  localparam int ST_RUN = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ppu_line_doubler_if #(.PIX_W(PIX_W)) bus ();

  ppu_line_doubler #(.PIX_W(PIX_W)) dut (
    .Clk         (clk),
    .reset_rtl_0 (rst),
    .bus         (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model of the frame: line memories, bank bookkeeping, stale counter.
  logic [5:0] m_mem [2][256];
  bit         m_valid [2];
  int         m_tag [2];
  int         m_mode;
  bit         m_ok;
  int         m_cnt;
  bit         m_under;
  bit         model_ready = 1'b0;
  // Pixel request captured at the previous edge, resolved at the next one.
  bit         p_vld, p_win, p_stale, p_run;
  int         p_bank, p_x;
  // {pix_active, pix_out} values in the order the DUT must present them.
  logic [6:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      m_valid[0] = 0; m_valid[1] = 0;
      m_mode = ST_WAIT; m_ok = 0; m_cnt = 0; m_under = 0; p_vld = 0;
      exp_q.delete();
      exp_q.push_back(7'h00);
      model_ready = 1'b1;
      return;
    end
    if (p_vld) begin
      if (!p_run || !p_win) exp_q.push_back(7'h00);
      else if (p_stale)     exp_q.push_back({1'b1, 6'h0F});
      else                  exp_q.push_back({1'b1, m_mem[p_bank][p_x]});
    end
    p_vld = 0;
    if (bus.vga_pix_en) begin
      int dx, dy, sy;
      dx = int'(bus.draw_x);
      dy = int'(bus.draw_y);
      sy = dy / 2;
      if (m_mode == ST_RUN && dx == 64 && dy < 480) begin
        m_ok = m_valid[sy % 2] && (m_tag[sy % 2] == sy);
        if (!m_ok && (dy % 2) == 0) begin
          m_under = 1;
          if (m_cnt < 255) m_cnt++;
        end
      end
      p_vld = 1;
      p_win = (dx >= 64) && (dx < 576) && (dy < 480);
      p_stale = !m_ok;
      p_run = (m_mode == ST_RUN);
      p_bank = sy % 2;
      p_x = p_win ? (dx - 64) / 2 : 0;
    end
    if (bus.ppu_pix_valid && int'(bus.ppu_y) < 240) begin
      int x, y;
      x = int'(bus.ppu_x);
      y = int'(bus.ppu_y);
      if (m_mode == ST_WAIT && x == 0 && y == 0) m_mode = ST_FILL;
      else if (m_mode == ST_FILL && x == 255 && y == 0) m_mode = ST_RUN;
      m_mem[y % 2][x] = bus.ppu_pix;
      if (x == 0) m_valid[y % 2] = 0;
      if (x == 255) begin
        m_valid[y % 2] = 1;
        m_tag[y % 2] = y;
      end
    end
  endtask

  // Compare process: every cycle after the first reset edge.
  initial begin
    logic [6:0] hold;
    hold = 7'h00;
    forever begin
      @(negedge clk);
      if (model_ready) begin
        while (exp_q.size() > 0) hold = exp_q.pop_front();
        check("pix_out", 32'(bus.pix_out), 32'(hold[5:0]));
        check("pix_active", 32'(bus.pix_active), 32'(hold[6]));
        check("underrun", 32'(bus.underrun), 32'(m_under));
        check("underrun_cnt", 32'(bus.underrun_cnt), 32'(m_cnt));
        check("state", 32'(bus.dbg_state), 32'(m_mode));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    bus.vga_pix_en = 1'b0;
    bus.ppu_pix_valid = 1'b0;
    tick();
  endtask

  task automatic vga_px(input int x, input int y);
    bus.ppu_pix_valid = 1'b0;
    bus.vga_pix_en = 1'b1;
    bus.draw_x = 10'(x);
    bus.draw_y = 10'(y);
    tick();
    bus.vga_pix_en = 1'b0;
  endtask

  task automatic vga_row(input int y);
    for (int x = 0; x < 800; x++) vga_px(x, y);
  endtask

  task automatic ppu_px(input int x, input int y, input int pix);
    bus.vga_pix_en = 1'b0;
    bus.ppu_pix_valid = 1'b1;
    bus.ppu_x = 8'(x);
    bus.ppu_y = 9'(y);
    bus.ppu_pix = 6'(pix);
    tick();
    bus.ppu_pix_valid = 1'b0;
  endtask

  task automatic ppu_line(input int y, input int seed);
    for (int x = 0; x < 256; x++) ppu_px(x, y, (x + seed) % 64);
  endtask

  // Single request, then the hand-computed value two cycles later.
  task automatic probe(input string name, input int x, input int y, input int pix, input int act);
    vga_px(x, y);
    idle();
    @(negedge clk);
    check({name, "_pix"}, 32'(bus.pix_out), 32'(pix));
    check({name, "_act"}, 32'(bus.pix_active), 32'(act));
  endtask

  initial begin
    bus.ppu_pix_valid = 1'b0;
    bus.ppu_x = '0;
    bus.ppu_y = '0;
    bus.ppu_pix = '0;
    bus.vga_pix_en = 1'b0;
    bus.draw_x = '0;
    bus.draw_y = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_pix", 32'(bus.pix_out), 32'd0);
    check("rst_act", 32'(bus.pix_active), 32'd0);
    check("rst_under", 32'(bus.underrun), 32'd0);
    check("rst_cnt", 32'(bus.underrun_cnt), 32'd0);
    check("rst_state", 32'(bus.dbg_state), ST_WAIT);

    // No PPU activity: nothing may become active.
    vga_row(0);
    probe("idle_row", 100, 0, 0, 0);

    // Line 0 as pix = x[5:0], line 1 as (x+7)[5:0].
    ppu_line(0, 0);
    @(negedge clk);
    check("run_after_line0", 32'(bus.dbg_state), ST_RUN);
    ppu_line(1, 7);
    for (int y = 0; y < 4; y++) vga_row(y);
    probe("c64_r0", 64, 0, 0, 1);
    probe("c65_r1", 65, 1, 0, 1);
    probe("c67_r1", 67, 1, 1, 1);
    probe("c575_r0", 575, 0, 6'h3F, 1);
    probe("c576_r0", 576, 0, 0, 0);
    probe("c63_r1", 63, 1, 0, 0);
    probe("c64_r2", 64, 2, 7, 1);
    probe("c575_r3", 575, 3, 6, 1);

    // Latency: nothing visible one cycle after the request, value after two.
    probe("lat_pre", 64, 0, 0, 1);
    vga_px(66, 0);
    @(negedge clk);
    check("lat_1cyc", 32'(bus.pix_out), 32'd0);
    idle();
    @(negedge clk);
    check("lat_2cyc", 32'(bus.pix_out), 32'd1);

    // Read-first: the write lands on the edge that reads the same address.
    vga_px(66, 0);
    ppu_px(1, 0, 6'h33);
    @(negedge clk);
    check("read_first_old", 32'(bus.pix_out), 32'd1);
    probe("read_first_new", 66, 0, 6'h33, 1);
    ppu_px(1, 0, 1);

    // Stale line: row 4 wants source line 2, bank 0 still holds line 0.
    vga_row(4);
    @(negedge clk);
    check("stale_under", 32'(bus.underrun), 32'd1);
    check("stale_cnt_r4", 32'(bus.underrun_cnt), 32'd1);
    vga_row(5);
    @(negedge clk);
    check("stale_cnt_r5", 32'(bus.underrun_cnt), 32'd1);
    probe("stale_pix", 100, 5, 6'h0F, 1);

    // Off-screen PPU lines must not touch RAM or bank state.
    ppu_line(240, 42);
    vga_row(0);
    vga_row(2);
    probe("y240_r0", 66, 0, 1, 1);
    probe("y240_r2", 575, 2, 6, 1);
    @(negedge clk);
    check("y240_cnt", 32'(bus.underrun_cnt), 32'd1);

    // Two sweeps of stale row starts drive the counter into saturation.
    for (int pass = 0; pass < 2; pass++) begin
      for (int y = 4; y < 480; y += 2) vga_px(64, y);
    end
    idle();
    @(negedge clk);
    check("sat_cnt", 32'(bus.underrun_cnt), 32'd255);

    // Reset in the middle of a visible row.
    for (int x = 0; x < 300; x++) vga_px(x, 0);
    rst = 1'b1;
    vga_px(300, 0);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_pix", 32'(bus.pix_out), 32'd0);
    check("mid_rst_act", 32'(bus.pix_active), 32'd0);
    check("mid_rst_state", 32'(bus.dbg_state), ST_WAIT);
    check("mid_rst_cnt", 32'(bus.underrun_cnt), 32'd0);
    for (int x = 301; x < 800; x++) vga_px(x, 0);
    probe("post_rst_wait", 100, 0, 0, 0);
    ppu_px(0, 0, 20);
    @(negedge clk);
    check("post_rst_fill", 32'(bus.dbg_state), ST_FILL);
    probe("post_rst_fill", 100, 0, 0, 0);
    for (int x = 1; x < 256; x++) ppu_px(x, 0, (x + 20) % 64);
    @(negedge clk);
    check("post_rst_run", 32'(bus.dbg_state), ST_RUN);
    vga_row(0);
    vga_row(1);
    probe("post_rst_c64", 64, 0, 20, 1);
    probe("post_rst_c575", 575, 1, 19, 1);
    idle();
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
